// File: rtl/ultrasonic_ranger_if.sv
`default_nettype none
// ==================================================================
// Module   : ultrasonic_ranger_if -- sensor pins and measurement results
// Revision : 1.0
// ==================================================================
interface ultrasonic_ranger_if #(
  parameter int CNT_W = 24
);
  logic             enable;
  logic             echo_in;
  logic             trig_out;
  logic [CNT_W-1:0] dist_cycles;
  logic             valid;
  logic             timeout;
  logic             busy;

  // master is the ranger itself; slave is the register/sensor side
  modport master (
    input  enable, echo_in,
    output trig_out, dist_cycles, valid, timeout, busy
  );

  modport slave (
    output enable, echo_in,
    input  trig_out, dist_cycles, valid, timeout, busy
  );
endinterface
`default_nettype wire

// File: rtl/ultrasonic_ranger.sv
`default_nettype none
// ==================================================================
// Module   : ultrasonic_ranger -- periodic trigger, echo width timer
// Revision : 1.0
// ==================================================================
module ultrasonic_ranger #(
  parameter int TRIG_CYCLES    = 1000,
  parameter int PERIOD_CYCLES  = 6000000,
  parameter int TIMEOUT_CYCLES = 3000000,
  parameter int CNT_W          = 24
) (
  input  wire logic           mclk,
  input  wire logic           rst_n,
  ultrasonic_ranger_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_TRIG      = 3'd1,
    S_WAIT_RISE = 3'd2,
    S_MEASURE   = 3'd3,
    S_HOLDOFF   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] C_TRIG_LAST   = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_WAIT_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_WIDTH_MAX   = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] C_PERIOD_LAST = CNT_W'(PERIOD_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_ONE         = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_valid_nxt;
  logic             w_timeout_nxt;
  logic             w_rise;
  logic             r_echo_prev;
  logic             r_trig;
  logic             r_valid;
  logic             r_timeout;
  logic [CNT_W-1:0] r_dist;
  logic [CNT_W-1:0] r_trig_cnt;
  logic [CNT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0] r_width_cnt;
  logic [CNT_W-1:0] r_period_cnt;

  assign w_rise = bus.echo_in & ~r_echo_prev;

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_valid_nxt   = 1'b0;
    w_timeout_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.enable) w_state_nxt = S_TRIG;
      end
      S_TRIG: begin
        if (r_trig_cnt == C_TRIG_LAST) w_state_nxt = S_WAIT_RISE;
      end
      S_WAIT_RISE: begin
        // an echo already high on entry never produces a rise, so it times out
        if (w_rise) begin
          w_state_nxt = S_MEASURE;
        end else if (r_wait_cnt == C_WAIT_LAST) begin
          w_timeout_nxt = 1'b1;
          w_state_nxt   = S_HOLDOFF;
        end
      end
      S_MEASURE: begin
        if (!bus.echo_in) begin
          w_valid_nxt = 1'b1;
          w_state_nxt = S_HOLDOFF;
        end else if (r_width_cnt == C_WIDTH_MAX) begin
          w_timeout_nxt = 1'b1;
          w_state_nxt   = S_HOLDOFF;
        end
      end
      S_HOLDOFF: begin
        if (r_period_cnt == C_PERIOD_LAST) w_state_nxt = bus.enable ? S_TRIG : S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      r_echo_prev  <= 1'b0;
      r_trig       <= 1'b0;
      r_valid      <= 1'b0;
      r_timeout    <= 1'b0;
      r_dist       <= '0;
      r_trig_cnt   <= '0;
      r_wait_cnt   <= '0;
      r_width_cnt  <= '0;
      r_period_cnt <= '0;
    end else begin
      r_echo_prev <= bus.echo_in;
      r_trig      <= (w_state_nxt == S_TRIG);
      r_valid     <= w_valid_nxt;
      r_timeout   <= w_timeout_nxt;
      if (w_valid_nxt) r_dist <= r_width_cnt;

      r_trig_cnt <= (r_state == S_TRIG && w_state_nxt == S_TRIG) ? r_trig_cnt + C_ONE : '0;
      r_wait_cnt <= (r_state == S_WAIT_RISE && w_state_nxt == S_WAIT_RISE) ? r_wait_cnt + C_ONE : '0;

      // the cycle that produced the rise is already one high sample
      if (w_state_nxt == S_MEASURE) begin
        r_width_cnt <= (r_state == S_MEASURE) ? r_width_cnt + C_ONE : C_ONE;
      end else begin
        r_width_cnt <= '0;
      end

      if (w_state_nxt == S_TRIG && r_state != S_TRIG) begin
        r_period_cnt <= '0;
      end else if (r_state != S_IDLE) begin
        r_period_cnt <= r_period_cnt + C_ONE;
      end
    end
  end

  assign bus.trig_out    = r_trig;
  assign bus.dist_cycles = r_dist;
  assign bus.valid       = r_valid;
  assign bus.timeout     = r_timeout;
  assign bus.busy        = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ultrasonic_ranger.sv
`default_nettype none
// ==================================================================
// Module   : tb_ultrasonic_ranger -- randomized periods vs arithmetic model
// Revision : 1.0
// ==================================================================
module tb_ultrasonic_ranger;

  localparam int TRIG = 4;
  localparam int TMO  = 40;
  localparam int PER  = 100;
  localparam int CW   = 24;

  logic mclk  = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   m_dist = 0;

  ultrasonic_ranger_if #(.CNT_W(CW)) bus ();

  ultrasonic_ranger #(
    .TRIG_CYCLES   (TRIG),
    .PERIOD_CYCLES (PER),
    .TIMEOUT_CYCLES(TMO),
    .CNT_W         (CW)
  ) dut (
    .mclk (mclk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  always #5 mclk = ~mclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Cycle indices are relative to the trigger rise (cycle 0); -1 means "no strobe".
  function automatic void predict(input int r, input int w, input bit stuck,
                                  output int v_at, output int t_at);
    v_at = -1;
    t_at = -1;
    if (!stuck && w > 0 && r >= TRIG && r < TRIG + TMO) begin
      if (w <= TMO) v_at = r + w + 1;
      else          t_at = r + TMO + 1;
    end else begin
      t_at = TRIG + TMO;
    end
  endfunction

  // Entered right after the edge that raised trig_out; leaves one period later.
  task automatic do_period(input string tag, input int r, input int w,
                           input bit stuck, input int drop_at);
    int v_at, t_at, exp_next;
    int trig_bad, busy_low, v_cnt, t_cnt, v_idx, t_idx;
    trig_bad = 0; busy_low = 0; v_cnt = 0; t_cnt = 0; v_idx = -1; t_idx = -1;
    predict(r, w, stuck, v_at, t_at);
    exp_next = (drop_at >= 0) ? 0 : 1;
    for (int k = 0; k < PER; k++) begin
      if (bus.trig_out !== (k < TRIG)) trig_bad++;
      if (bus.busy !== 1'b1) busy_low++;
      if (bus.valid === 1'b1) begin v_cnt++; v_idx = k; end
      if (bus.timeout === 1'b1) begin t_cnt++; t_idx = k; end
      if (k == drop_at) bus.enable = 1'b0;
      bus.echo_in = stuck || (k >= r && k < r + w);
      @(posedge mclk); #1;
    end
    if (v_at >= 0) m_dist = w;
    check({tag, " trig_shape"}, trig_bad, 0);
    check({tag, " busy_low"}, busy_low, 0);
    check({tag, " valid_count"}, v_cnt, (v_at >= 0) ? 1 : 0);
    check({tag, " valid_cycle"}, v_idx, v_at);
    check({tag, " timeout_count"}, t_cnt, (t_at >= 0) ? 1 : 0);
    check({tag, " timeout_cycle"}, t_idx, t_at);
    check({tag, " dist"}, bus.dist_cycles, m_dist);
    check({tag, " next_trig"}, bus.trig_out, exp_next);
    check({tag, " next_busy"}, bus.busy, exp_next);
  endtask

  initial begin
    int hits;
    bus.enable  = 1'b0;
    bus.echo_in = 1'b0;
    repeat (3) @(posedge mclk);
    #1;
    check("rst trig", bus.trig_out, 0);
    check("rst dist", bus.dist_cycles, 0);
    check("rst valid", bus.valid, 0);
    check("rst timeout", bus.timeout, 0);
    check("rst busy", bus.busy, 0);

    bus.enable = 1'b1;
    @(negedge mclk);
    rst_n = 1'b1;
    @(posedge mclk); #1;
    check("start trig", bus.trig_out, 1);

    do_period("p1 echo17", 14, 17, 1'b0, -1);
    do_period("p2 noecho", 0, 0, 1'b0, -1);
    do_period("p3 stuck_a", 0, 0, 1'b1, -1);
    do_period("p3 stuck_b", 0, 0, 1'b1, -1);
    do_period("p4 long45", 10, 45, 1'b0, -1);
    do_period("p4 short1", 10, 1, 1'b0, -1);

    for (int i = 0; i < 10; i++) begin
      int rr, ww;
      rr = $urandom_range(0, 50);
      ww = ($urandom_range(0, 3) == 0) ? $urandom_range(42, 50) : $urandom_range(1, 39);
      do_period("rnd", rr, ww, 1'b0, -1);
    end

    do_period("p5 drop", 10, 8, 1'b0, 12);
    hits = 0;
    for (int k = 0; k < 150; k++) begin
      if (bus.trig_out !== 1'b0 || bus.busy !== 1'b0 || bus.valid !== 1'b0 || bus.timeout !== 1'b0)
        hits++;
      @(posedge mclk); #1;
    end
    check("p5 idle_quiet", hits, 0);
    check("p5 idle_dist", bus.dist_cycles, m_dist);

    bus.enable = 1'b1;
    @(posedge mclk); #1;
    check("p6 trig_from_idle", bus.trig_out, 1);
    @(posedge mclk); #1;
    #2 rst_n = 1'b0;
    #1;
    check("p6 async_trig", bus.trig_out, 0);
    check("p6 async_busy", bus.busy, 0);
    check("p6 async_dist", bus.dist_cycles, 0);
    m_dist = 0;
    hits = 0;
    repeat (3) begin
      @(posedge mclk); #1;
      if (bus.trig_out !== 1'b0 || bus.busy !== 1'b0 || bus.valid !== 1'b0 || bus.timeout !== 1'b0)
        hits++;
    end
    check("p6 held_quiet", hits, 0);
    @(negedge mclk);
    rst_n = 1'b1;
    @(posedge mclk); #1;
    do_period("p6 restart", 20, 5, 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
